// File: rtl/ibex_pkg.sv
// Shared PMP types: region configuration payload, CSR stage FSM states and sizing constants.
package ibex_pkg;

  localparam int unsigned PMP_MAX_REGIONS = 16;
  localparam int unsigned PMP_CFG_W       = 4;
  localparam int unsigned PMP_IDX_W       = 4;

  typedef struct packed {
    logic lock;
    logic exec;
    logic write;
    logic read;
  } pmp_cfg_t;

  localparam pmp_cfg_t PMP_CFG_RST = '0;

  typedef enum logic [1:0] {
    PMP_CSR_IDLE = 2'd0,
    PMP_CSR_EXEC = 2'd1,
    PMP_CSR_RESP = 2'd2
  } pmp_csr_state_e;

endpackage

// File: rtl/pmp_cfg_legalize.sv
// Maps raw CSR write data onto a legal pmp_cfg_t (W without R is reserved and reads back as W=0).
module pmp_cfg_legalize
  import ibex_pkg::*;
(
  input  logic [PMP_CFG_W-1:0] wdata_i,
  output pmp_cfg_t             legal_cfg_c
);

  always_comb begin
    legal_cfg_c = pmp_cfg_t'(wdata_i);
    if (legal_cfg_c.write && !legal_cfg_c.read) begin
      legal_cfg_c.write = 1'b0;
    end
  end

endmodule

// File: rtl/pmp_cfg_csr.sv
// PMP configuration CSR write/readback stage: request FSM, lock check and per-region storage.
// Build macro PMP_CFG_SHADOW_EN adds inverted shadow copies with a sticky integrity alarm.
module pmp_cfg_csr
  import ibex_pkg::*;
#(
  parameter bit          PMPEnable     = 1'b1,
  parameter int unsigned PMPNumRegions = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic                         req_we_i,
  input  logic [PMP_IDX_W-1:0]         req_idx_i,
  input  logic [PMP_CFG_W-1:0]         req_wdata_i,
  output logic                         rsp_valid_o,
  input  logic                         rsp_ready_i,
  output logic [PMP_CFG_W-1:0]         rsp_rdata_o,
  output logic                         rsp_err_o,
  output logic                         cfg_update_o,
  output pmp_cfg_t [PMPNumRegions-1:0] pmp_cfg_o,
  output logic                         shadow_alarm_o
);

  localparam int unsigned IdxCmpW = PMP_IDX_W + 1;

  pmp_csr_state_e r_state, w_state_nxt;
  logic           w_accept;
  logic           w_exec;

  logic                 r_we;
  logic [PMP_IDX_W-1:0] r_idx;
  logic [PMP_CFG_W-1:0] r_wdata;

  logic     r_req_ready, r_rsp_valid, r_rsp_err, r_cfg_update;
  pmp_cfg_t r_rsp_rdata;

  pmp_cfg_t [PMPNumRegions-1:0] w_cfg;
  pmp_cfg_t w_cur, w_legal, w_rdata;
  logic     w_idx_ok, w_locked, w_err, w_do_write, w_changed;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= PMP_CSR_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state: one request in flight, EXEC always lasts exactly one cycle
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_exec      = 1'b0;
    case (r_state)
      PMP_CSR_IDLE: begin
        if (req_valid_i) begin
          w_accept    = 1'b1;
          w_state_nxt = PMP_CSR_EXEC;
        end
      end
      PMP_CSR_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = PMP_CSR_RESP;
      end
      PMP_CSR_RESP: begin
        if (rsp_ready_i) w_state_nxt = PMP_CSR_IDLE;
      end
      default: w_state_nxt = PMP_CSR_IDLE;
    endcase
  end

  // Request capture
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we_i;
      r_idx   <= req_idx_i;
      r_wdata <= req_wdata_i;
    end
  end

  pmp_cfg_legalize u_legalize (
    .wdata_i     (r_wdata),
    .legal_cfg_c (w_legal)
  );

  // Current value of the addressed region (zero when out of range)
  always_comb begin
    w_cur = PMP_CFG_RST;
    for (int unsigned i = 0; i < PMPNumRegions; i++) begin
      if (r_idx == PMP_IDX_W'(i)) w_cur = w_cfg[i];
    end
  end

  assign w_idx_ok   = ({1'b0, r_idx} < IdxCmpW'(PMPNumRegions));
  assign w_locked   = w_idx_ok & w_cur.lock;
  assign w_err      = PMPEnable & (!w_idx_ok | (r_we & w_locked));
  assign w_do_write = PMPEnable & r_we & w_idx_ok & !w_locked;
  assign w_changed  = w_do_write & (w_legal != w_cur);
  assign w_rdata    = w_idx_ok ? w_cur : PMP_CFG_RST;

  if (PMPEnable) begin : g_storage
    pmp_cfg_t [PMPNumRegions-1:0] r_cfg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cfg <= {PMPNumRegions{PMP_CFG_RST}};
      end else if (w_exec && w_do_write) begin
        for (int unsigned i = 0; i < PMPNumRegions; i++) begin
          if (r_idx == PMP_IDX_W'(i)) r_cfg[i] <= w_legal;
        end
      end
    end

    assign w_cfg = r_cfg;
  end else begin : g_no_storage
    assign w_cfg = {PMPNumRegions{PMP_CFG_RST}};
  end

  // Response and handshake outputs, registered off the next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rdata  <= PMP_CFG_RST;
      r_cfg_update <= 1'b0;
    end else begin
      r_req_ready  <= (w_state_nxt == PMP_CSR_IDLE);
      r_rsp_valid  <= (w_state_nxt == PMP_CSR_RESP);
      r_cfg_update <= w_exec & w_changed;
      if (w_exec) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= w_rdata;
      end
    end
  end

`ifdef PMP_CFG_SHADOW_EN
  pmp_cfg_t [PMPNumRegions-1:0] r_shadow;
  logic                         r_alarm;

  // Shadow holds the inverse of each region, written on the same edge as the primary
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shadow <= {PMPNumRegions{pmp_cfg_t'(~PMP_CFG_RST)}};
      r_alarm  <= 1'b0;
    end else begin
      r_alarm <= r_alarm | (w_cfg != ~r_shadow);
      if (w_exec && w_do_write) begin
        for (int unsigned i = 0; i < PMPNumRegions; i++) begin
          if (r_idx == PMP_IDX_W'(i)) r_shadow[i] <= pmp_cfg_t'(~w_legal);
        end
      end
    end
  end

  assign shadow_alarm_o = r_alarm;
`else
  assign shadow_alarm_o = 1'b0;
`endif

  assign req_ready_o  = r_req_ready;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_err_o    = r_rsp_err;
  assign rsp_rdata_o  = r_rsp_rdata;
  assign cfg_update_o = r_cfg_update;
  assign pmp_cfg_o    = w_cfg;

endmodule

// File: tb/tb_pmp_cfg_csr.sv
// Self-checking bench for pmp_cfg_csr: reference model feeds a response scoreboard queue.
// Shadow alarm scenario is exercised only when PMP_CFG_SHADOW_EN is defined.
module tb_pmp_cfg_csr;
  import ibex_pkg::*;

  localparam int unsigned NREG = 2;

  typedef struct {
    logic [3:0] rdata;
    logic       err;
    logic       upd;
  } exp_t;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  logic                req_we_i = 1'b0;
  logic [3:0]          req_idx_i = '0;
  logic [3:0]          req_wdata_i = '0;
  logic                rsp_valid_o;
  logic                rsp_ready_i = 1'b0;
  logic [3:0]          rsp_rdata_o;
  logic                rsp_err_o;
  logic                cfg_update_o;
  pmp_cfg_t [NREG-1:0] pmp_cfg_o;
  logic                shadow_alarm_o;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic [3:0] model [NREG];

  pmp_cfg_csr #(.PMPEnable(1'b1), .PMPNumRegions(NREG)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_idx_i      (req_idx_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .cfg_update_o   (cfg_update_o),
    .pmp_cfg_o      (pmp_cfg_o),
    .shadow_alarm_o (shadow_alarm_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] model_vec();
    return {model[1], model[0]};
  endfunction

  // Accept one request and push the model's expected response
  task automatic issue(input logic we, input logic [3:0] idx, input logic [3:0] wdata);
    exp_t e;
    logic [3:0] legal;
    int n = 0;
    while (req_ready_o !== 1'b1 && n < 10) begin
      @(posedge clk_i); #1; n++;
    end
    checks++;
    if (req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL issue_ready_timeout got=%b want=1", req_ready_o);
    end
    req_valid_i = 1'b1; req_we_i = we; req_idx_i = idx; req_wdata_i = wdata;
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    e.upd = 1'b0;
    if (idx >= NREG) begin
      e.rdata = 4'b0000; e.err = 1'b1;
    end else if (!we) begin
      e.rdata = model[idx]; e.err = 1'b0;
    end else if (model[idx][3]) begin
      e.rdata = model[idx]; e.err = 1'b1;
    end else begin
      legal = wdata;
      if (legal[1] && !legal[0]) legal[1] = 1'b0;
      e.rdata = model[idx]; e.err = 1'b0;
      e.upd = (legal != model[idx]);
      model[idx] = legal;
    end
    exp_q.push_back(e);
  endtask

  // Wait for the response, check latency, payload, stall stability and handshake
  task automatic collect(input int stall);
    exp_t e;
    int n = 0;
    e = exp_q.pop_front();
    while (rsp_valid_o !== 1'b1 && n < 8) begin
      @(posedge clk_i); #1; n++;
    end
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL rsp_latency got=%0d edges want=1", n);
    end
    checks++;
    if (rsp_rdata_o !== e.rdata) begin
      failures++;
      $display("FAIL rsp_rdata got=%b want=%b", rsp_rdata_o, e.rdata);
    end
    checks++;
    if (rsp_err_o !== e.err) begin
      failures++;
      $display("FAIL rsp_err got=%b want=%b", rsp_err_o, e.err);
    end
    checks++;
    if (cfg_update_o !== e.upd) begin
      failures++;
      $display("FAIL cfg_update got=%b want=%b", cfg_update_o, e.upd);
    end
    checks++;
    if (pmp_cfg_o !== model_vec()) begin
      failures++;
      $display("FAIL pmp_cfg got=%b want=%b", pmp_cfg_o, model_vec());
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk_i); #1;
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err ||
          cfg_update_o !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold got=v%b d%b e%b u%b want=v1 d%b e%b u0",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, cfg_update_o, e.rdata, e.err);
      end
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rsp_handshake got=v%b r%b want=v0 r1", rsp_valid_o, req_ready_o);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    checks++;
    if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 ||
        rsp_rdata_o !== 4'b0000 || cfg_update_o !== 1'b0 || shadow_alarm_o !== 1'b0 ||
        pmp_cfg_o !== 8'h00) begin
      failures++;
      $display("FAIL %s got=r%b v%b e%b d%b u%b a%b cfg=%b want=r1 v0 e0 d0000 u0 a0 cfg=0",
               tag, req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, cfg_update_o,
               shadow_alarm_o, pmp_cfg_o);
    end
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    #13;
    for (int i = 0; i < NREG; i++) model[i] = 4'b0000;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    check_idle_reset("reset_state");
  endtask

  task automatic test_write_basic();
    issue(1'b1, 4'd0, 4'b0011);
    collect(0);
    checks++;
    if (pmp_cfg_o[0] !== 4'b0011) begin
      failures++;
      $display("FAIL write_basic_cfg0 got=%b want=0011", pmp_cfg_o[0]);
    end
  endtask

  task automatic test_legalize();
    issue(1'b1, 4'd1, 4'b0010);
    collect(0);
    checks++;
    if (pmp_cfg_o[1] !== 4'b0000) begin
      failures++;
      $display("FAIL legalize_w_only got=%b want=0000", pmp_cfg_o[1]);
    end
    issue(1'b1, 4'd1, 4'b0110);
    collect(0);
    issue(1'b1, 4'd1, 4'b0110);
    collect(0);
  endtask

  task automatic test_lock();
    issue(1'b1, 4'd0, 4'b1001);
    collect(0);
    issue(1'b1, 4'd0, 4'b0111);
    collect(0);
    checks++;
    if (pmp_cfg_o[0] !== 4'b1001) begin
      failures++;
      $display("FAIL lock_hold_cfg0 got=%b want=1001", pmp_cfg_o[0]);
    end
    issue(1'b0, 4'd0, 4'b0000);
    collect(0);
  endtask

  task automatic test_out_of_range();
    issue(1'b0, 4'd5, 4'b0000);
    collect(0);
    issue(1'b1, 4'd15, 4'b0001);
    collect(0);
  endtask

  task automatic test_stall();
    issue(1'b1, 4'd1, 4'b0101);
    collect(3);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 12; k++) begin
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 7)));
      collect(0);
    end
  endtask

  task automatic test_reset_in_exec();
    issue(1'b1, 4'd1, 4'b0111);
    void'(exp_q.pop_front());
    rst_ni = 1'b0;
    #1;
    for (int i = 0; i < NREG; i++) model[i] = 4'b0000;
    check_idle_reset("reset_in_exec");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
    end
    check_idle_reset("after_reset_no_rsp");
  endtask

`ifdef PMP_CFG_SHADOW_EN
  task automatic test_shadow();
    @(negedge clk_i);
    force dut.r_shadow = {4'b1111, 4'b1110};
    @(posedge clk_i); #1;
    release dut.r_shadow;
    checks++;
    if (shadow_alarm_o !== 1'b1) begin
      failures++;
      $display("FAIL shadow_alarm_raise got=%b want=1", shadow_alarm_o);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i); #1;
    end
    checks++;
    if (shadow_alarm_o !== 1'b1) begin
      failures++;
      $display("FAIL shadow_alarm_sticky got=%b want=1", shadow_alarm_o);
    end
    apply_reset();
    check_idle_reset("shadow_reset_clear");
  endtask
`endif

  initial begin
    test_reset();
    test_write_basic();
    test_legalize();
    test_lock();
    test_out_of_range();
    test_stall();
    test_back_to_back();
    test_reset_in_exec();
`ifdef PMP_CFG_SHADOW_EN
    test_shadow();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
